uart_tx_serializer: RTL and testbench

//   Serial transmitter downstream of the clock divider. It uses the divided

---
 rtl/uart_tx_serializer.sv | 86 ++++++++
 tb/tb_uart_tx_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART frame transmitter (start, LSB-first data, stop) paced by an
// asynchronous baud reference that is synchronised and edge-detected on clock_100.
module uart_tx_serializer #(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int TICKS_PER_BIT = 72
) (
    input  logic                 clock_100,
    input  logic                 reset_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int TW = TICKS_PER_BIT > 1 ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t               state;
    logic                 s1, s2, s3;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick, bit_end, last_data, last_stop;
    assign tick      = s2 & ~s3;
    assign bit_end   = tick && tick_cnt == TW'(TICKS_PER_BIT - 1);
    assign last_data = bit_cnt == BW'(DATA_BITS - 1);
    assign last_stop = bit_cnt == BW'(STOP_BITS - 1);
    always_ff @(posedge clock_100 or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= baud_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end
    // a tick coinciding with accept is dropped because the FSM is still in IDLE then
    always_ff @(posedge clock_100 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            if (state != IDLE && tick)
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            case (state)
                IDLE: if (tx_valid && tx_ready) begin
                    state    <= START;
                    shift    <= tx_data;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b0;
                    tx_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= shift[0];
                end
                DATA: if (bit_end) begin
                    shift   <= shift >> 1;
                    bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
                    state   <= last_data ? STOP : DATA;
                    tx      <= last_data ? 1'b1 : shift[1];
                end
                STOP: if (bit_end) begin
                    bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
                    if (last_stop) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames with a byte scoreboard; a line monitor decodes
// each frame backwards from the busy fall, where every bit after the start is 48 cycles.
module tb_uart_tx_serializer;
    logic       clock_100 = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_clk;
    logic       baud_gen = 1'b0;
    logic       baud_man = 1'b0;
    bit         baud_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, busy;
    int         tests = 0;
    int         fails = 0;
    int         acc_cnt = 0;
    int         frames = 0;
    int         n = 0;
    int         fall_n = 0;
    int         end_n = 0;
    int         len;
    bit         in_frame = 1'b0;
    bit         prev_busy = 1'b0;
    logic       hist [512];
    logic [7:0] got, want;
    logic [7:0] exp_q [$];

    assign baud_clk = baud_gen | baud_man;

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .TICKS_PER_BIT(4)) dut (
        .clock_100(clock_100),
        .reset_n  (reset_n),
        .baud_clk (baud_clk),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial forever #5 clock_100 = ~clock_100;

    // 6 high / 6 low; when disabled the generator holds low so the bench can hand-drive edges
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clock_100);
            if (baud_en) begin
                cnt++;
                if (cnt == 6) begin
                    cnt = 0;
                    baud_gen = ~baud_gen;
                end
            end else begin
                cnt = 0;
                baud_gen = 1'b0;
            end
        end
    end

    always @(posedge clock_100)
        if (reset_n && tx_valid && tx_ready) begin
            acc_cnt++;
            exp_q.push_back(tx_data);
        end

    always @(negedge clock_100) begin
        n++;
        hist[n & 511] = tx;
        if (!reset_n) begin
            in_frame = 1'b0;
            exp_q.delete();
        end else begin
            if (!in_frame && !tx && busy) begin
                in_frame = 1'b1;
                fall_n = n;
            end
            if (prev_busy && !busy && in_frame) begin
                for (int i = 0; i < 8; i++) got[i] = hist[(n - (48 * (9 - i) - 24)) & 511];
                len = n - fall_n;
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_empty observed=frame expected=no_frame");
                end
                want = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
                tests++;
                assert (got === want) else begin
                    fails++;
                    $error("FAIL frame_data observed=%h expected=%h", got, want);
                end
                tests++;
                assert (hist[(n - 450) & 511] === 1'b0) else begin
                    fails++;
                    $error("FAIL start_bit observed=%b expected=0", hist[(n - 450) & 511]);
                end
                tests++;
                assert (hist[(n - 24) & 511] === 1'b1) else begin
                    fails++;
                    $error("FAIL stop_bit observed=%b expected=1", hist[(n - 24) & 511]);
                end
                tests++;
                assert (len >= 469 && len <= 480) else begin
                    fails++;
                    $error("FAIL frame_len observed=%0d expected=469..480", len);
                end
                frames++;
                end_n = n;
                in_frame = 1'b0;
            end
        end
        prev_busy = busy;
    end

    task automatic wait_acc(input int target);
        int k = 0;
        while (acc_cnt < target && k < 1000) begin
            @(negedge clock_100);
            k++;
        end
        tests++;
        assert (acc_cnt >= target) else begin
            fails++;
            $error("FAIL accept_timeout observed=%0d expected=%0d", acc_cnt, target);
        end
    endtask

    task automatic wait_frames(input int target);
        int k = 0;
        while (frames < target && k < 1500) begin
            @(negedge clock_100);
            k++;
        end
        tests++;
        assert (frames >= target) else begin
            fails++;
            $error("FAIL frame_timeout observed=%0d expected=%0d", frames, target);
        end
    endtask

    task automatic check_idle(input string tag);
        tests++;
        assert ({tx, tx_ready, busy} === 3'b110) else begin
            fails++;
            $error("FAIL %s observed=%b expected=110", tag, {tx, tx_ready, busy});
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock_100);
        tx_data = b;
        tx_valid = 1'b1;
        wait_acc(acc_cnt + 1);
        tx_valid = 1'b0;
    endtask

    initial begin
        int first;
        int base;
        // reset and quiet idle
        repeat (5) @(negedge clock_100);
        check_idle("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock_100);
            check_idle("idle_hold");
        end
        // single frame A5
        send(8'hA5);
        tests++;
        assert (tx_ready === 1'b0) else begin
            fails++;
            $error("FAIL ready_drop observed=%b expected=0", tx_ready);
        end
        wait_frames(1);
        // tx_valid held across two frames
        base = acc_cnt;
        @(negedge clock_100);
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        wait_acc(base + 1);
        tests++;
        assert (tx_ready === 1'b0) else begin
            fails++;
            $error("FAIL ready_drop1 observed=%b expected=0", tx_ready);
        end
        tx_data = 8'h00;
        wait_acc(base + 2);
        tests++;
        assert (tx_ready === 1'b0) else begin
            fails++;
            $error("FAIL ready_drop2 observed=%b expected=0", tx_ready);
        end
        tx_valid = 1'b0;
        @(negedge clock_100);
        tests++;
        assert (fall_n === end_n + 1) else begin
            fails++;
            $error("FAIL back_to_back observed=%0d expected=%0d", fall_n, end_n + 1);
        end
        wait_frames(3);
        repeat (20) @(negedge clock_100);
        tests++;
        assert (acc_cnt === base + 2) else begin
            fails++;
            $error("FAIL accept_count observed=%0d expected=%0d", acc_cnt, base + 2);
        end
        // data changes after accept are ignored
        send(8'hFF);
        tx_data = 8'h00;
        wait_frames(4);
        // asynchronous reset during data bit 3
        send(8'h00);
        repeat (205) @(negedge clock_100);
        tests++;
        assert ({tx, busy} === 2'b01) else begin
            fails++;
            $error("FAIL mid_frame observed=%b expected=01", {tx, busy});
        end
        #3 reset_n = 1'b0;
        #1 check_idle("async_reset");
        repeat (3) @(negedge clock_100);
        reset_n = 1'b1;
        send(8'h81);
        wait_frames(5);
        // single hand-driven baud edge while in START
        baud_en = 1'b0;
        repeat (15) @(negedge clock_100);
        send(8'h5A);
        repeat (3) @(negedge clock_100);
        tests++;
        assert ({busy, tx, dut.tick_cnt} === 4'b1000) else begin
            fails++;
            $error("FAIL start_hold observed=%b expected=1000", {busy, tx, dut.tick_cnt});
        end
        @(negedge clock_100);
        baud_man = 1'b1;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock_100);
            if (first == 0 && dut.tick_cnt != 2'd0) first = k;
        end
        tests++;
        assert (first >= 2 && first <= 3) else begin
            fails++;
            $error("FAIL sync_latency observed=%0d expected=2..3", first);
        end
        tests++;
        assert (dut.tick_cnt === 2'd1) else begin
            fails++;
            $error("FAIL single_tick observed=%0d expected=1", dut.tick_cnt);
        end
        #2 reset_n = 1'b0;
        baud_man = 1'b0;
        baud_en = 1'b1;
        repeat (3) @(negedge clock_100);
        check_idle("final_reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clock_100);
        tests++;
        assert (exp_q.size() === 0) else begin
            fails++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
